// File: rtl/mmc3_irq_counter.sv
// MMC3-style scanline IRQ counter.
// PPU A12 is resynchronised to m2 and low-time filtered. Each qualified
// rising edge clocks an 8-bit down counter that reloads from a CPU-written
// latch whenever it is zero or a reload has been requested. Reaching zero
// can raise an active-low IRQ, which is cleared only by a $E000 write or by
// reset. The two historical chip revisions differ only in whether reloading
// a zero latch into an already-zero counter raises the IRQ.
module mmc3_irq_counter #(
    parameter int A12_FILTER   = 3,   // low cycles required before a rise counts (1-15)
    parameter int MMC3_ALT_IRQ = 0    // 0 = new-revision IRQ, 1 = old-revision IRQ
) (
    input  logic       m2,
    input  logic       reset,
    input  logic       enable,
    input  logic       cpu_write,
    input  logic [1:0] reg_sel,
    input  logic [7:0] cpu_data,
    input  logic       ppu_a12,
    output logic       irq,
    output logic [7:0] counter_out
);

    localparam logic [3:0] FILTER_C = 4'(A12_FILTER);

    localparam logic [1:0] SEL_LATCH   = 2'd0;  // $C000
    localparam logic [1:0] SEL_RELOAD  = 2'd1;  // $C001
    localparam logic [1:0] SEL_DISABLE = 2'd2;  // $E000
    localparam logic [1:0] SEL_ENABLE  = 2'd3;  // $E001

    // A12 synchroniser and edge-history flops
    logic       a12_meta_q;
    logic       a12_s_q;
    logic       a12_prev_q;

    // Counter state
    logic [3:0] low_cnt_q,     low_cnt_d;
    logic [7:0] counter_q,     counter_d;
    logic [7:0] latch_q,       latch_d;
    logic       reload_flag_q, reload_flag_d;
    logic       irq_enable_q,  irq_enable_d;
    logic       irq_pending_q, irq_pending_d;

    // Event decode helpers
    logic       clk_event;
    logic       reload_now;
    logic [7:0] counter_evt;
    logic       irq_set;

    // Two-flop synchroniser for PPU A12, plus one more stage for edge detection
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            a12_meta_q <= 1'b0;
            a12_s_q    <= 1'b0;
            a12_prev_q <= 1'b0;
        end else begin
            a12_meta_q <= ppu_a12;
            a12_s_q    <= a12_meta_q;
            a12_prev_q <= a12_s_q;
        end
    end

    // Low-time filter, event decode, and CPU register writes (writes take priority)
    always_comb begin
        low_cnt_d     = low_cnt_q;
        counter_d     = counter_q;
        latch_d       = latch_q;
        reload_flag_d = reload_flag_q;
        irq_enable_d  = irq_enable_q;
        irq_pending_d = irq_pending_q;

        // Saturating count of cycles spent low; any high cycle restarts it.
        if (a12_s_q) begin
            low_cnt_d = 4'd0;
        end else if (low_cnt_q != FILTER_C) begin
            low_cnt_d = low_cnt_q + 4'd1;
        end

        clk_event   = enable && a12_s_q && !a12_prev_q && (low_cnt_q == FILTER_C);
        reload_now  = (counter_q == 8'd0) || reload_flag_q;
        // The old latch value is used here, so a same-cycle $C000 write
        // only affects later reloads.
        counter_evt = reload_now ? latch_q : (counter_q - 8'd1);

        if (MMC3_ALT_IRQ != 0) begin
            // Old revision: a zero reloaded into a zero counter stays silent
            // unless a reload was explicitly requested.
            irq_set = (counter_evt == 8'd0) && irq_enable_q &&
                      ((counter_q != 8'd0) || reload_flag_q);
        end else begin
            irq_set = (counter_evt == 8'd0) && irq_enable_q;
        end

        if (clk_event) begin
            counter_d     = counter_evt;
            reload_flag_d = 1'b0;
            if (irq_set) begin
                irq_pending_d = 1'b1;
            end
        end

        if (cpu_write) begin
            case (reg_sel)
                SEL_LATCH: begin
                    latch_d = cpu_data;
                end
                SEL_RELOAD: begin
                    // Overrides a coincident event entirely, including its IRQ.
                    counter_d     = 8'd0;
                    reload_flag_d = 1'b1;
                    irq_pending_d = irq_pending_q;
                end
                SEL_DISABLE: begin
                    irq_enable_d  = 1'b0;
                    irq_pending_d = 1'b0;
                end
                default: begin
                    irq_enable_d = 1'b1;
                end
            endcase
        end
    end

    // Counter, latch and IRQ state registers
    always_ff @(posedge m2 or posedge reset) begin
        if (reset) begin
            low_cnt_q     <= 4'd0;
            counter_q     <= 8'd0;
            latch_q       <= 8'd0;
            reload_flag_q <= 1'b0;
            irq_enable_q  <= 1'b0;
            irq_pending_q <= 1'b0;
        end else begin
            low_cnt_q     <= low_cnt_d;
            counter_q     <= counter_d;
            latch_q       <= latch_d;
            reload_flag_q <= reload_flag_d;
            irq_enable_q  <= irq_enable_d;
            irq_pending_q <= irq_pending_d;
        end
    end

    assign irq         = ~irq_pending_q;
    assign counter_out = counter_q;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Directed bench for mmc3_irq_counter. Two instances share all inputs:
// dut0 uses the new-revision IRQ rule, dut1 the old-revision rule.
// Inputs change 1 ns after each rising m2 edge; outputs are checked there too.
module tb_mmc3_irq_counter;

    logic       m2;
    logic       reset;
    logic       enable;
    logic       cpu_write;
    logic [1:0] reg_sel;
    logic [7:0] cpu_data;
    logic       ppu_a12;
    logic       irq0, irq1;
    logic [7:0] cnt0, cnt1;

    int checks = 0;
    int passed = 0;

    mmc3_irq_counter #(.A12_FILTER(3), .MMC3_ALT_IRQ(0)) dut0 (
        .m2(m2), .reset(reset), .enable(enable), .cpu_write(cpu_write),
        .reg_sel(reg_sel), .cpu_data(cpu_data), .ppu_a12(ppu_a12),
        .irq(irq0), .counter_out(cnt0)
    );

    mmc3_irq_counter #(.A12_FILTER(3), .MMC3_ALT_IRQ(1)) dut1 (
        .m2(m2), .reset(reset), .enable(enable), .cpu_write(cpu_write),
        .reg_sel(reg_sel), .cpu_data(cpu_data), .ppu_a12(ppu_a12),
        .irq(irq1), .counter_out(cnt1)
    );

    initial begin
        m2 = 1'b0;
        forever #5 m2 = ~m2;
    end

    task automatic tick();
        @(posedge m2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] d);
        cpu_write = 1'b1;
        reg_sel   = sel;
        cpu_data  = d;
        tick();
        cpu_write = 1'b0;
    endtask

    // 4 low cycles, 1 high cycle at the pins; the event lands on the 3rd edge
    // after the rise. An optional write is presented on that same edge.
    task automatic a12_event(input bit w, input logic [1:0] sel, input logic [7:0] d);
        ppu_a12 = 1'b0;
        repeat (4) tick();
        ppu_a12 = 1'b1;
        tick();
        ppu_a12 = 1'b0;
        tick();
        if (w) begin
            cpu_write = 1'b1;
            reg_sel   = sel;
            cpu_data  = d;
        end
        tick();
        cpu_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; cpu_write = 1'b0;
        reg_sel = 2'd0; cpu_data = 8'd0; ppu_a12 = 1'b0;
        repeat (2) tick();
        chk("rst_irq0", {7'd0, irq0}, 8'd1);
        chk("rst_irq1", {7'd0, irq1}, 8'd1);
        chk("rst_cnt", cnt0, 8'd0);
        reset = 1'b0;
        repeat (2) tick();

        // latch=3, reload, enable, then count 3,2,1,0
        wr(2'd0, 8'd3); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("ev1_cnt", cnt0, 8'd3);
        chk("ev1_irq0", {7'd0, irq0}, 8'd1);
        ppu_a12 = 1'b0;
        repeat (4) tick();
        ppu_a12 = 1'b1;
        tick();
        ppu_a12 = 1'b0;
        tick();
        chk("latency_2nd_edge", cnt0, 8'd3);
        tick();
        chk("ev2_cnt", cnt0, 8'd2);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("ev3_cnt", cnt0, 8'd1);
        chk("ev3_irq0", {7'd0, irq0}, 8'd1);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("ev4_cnt", cnt0, 8'd0);
        chk("ev4_irq0", {7'd0, irq0}, 8'd0);
        chk("ev4_irq1", {7'd0, irq1}, 8'd0);

        // rise after only 2 low cycles is filtered out (would reload 3)
        ppu_a12 = 1'b1;
        repeat (3) tick();
        chk("short_low_cnt", cnt0, 8'd0);
        ppu_a12 = 1'b0;

        // $E000 coincident with a zero-reaching event wins
        wr(2'd0, 8'd0);
        a12_event(1'b1, 2'd2, 8'd0);
        chk("ack_coinc_cnt", cnt0, 8'd0);
        chk("ack_coinc_irq0", {7'd0, irq0}, 8'd1);
        chk("ack_coinc_irq1", {7'd0, irq1}, 8'd1);
        wr(2'd3, 8'd0);
        chk("e001_only_irq0", {7'd0, irq0}, 8'd1);

        // zero reloaded into zero without reload request: revisions differ
        a12_event(1'b0, 2'd0, 8'd0);
        chk("zero_reload_irq0", {7'd0, irq0}, 8'd0);
        chk("zero_reload_irq1", {7'd0, irq1}, 8'd1);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("irq_sticky_irq0", {7'd0, irq0}, 8'd0);

        // latch=0 with explicit reload: both revisions raise IRQ
        wr(2'd2, 8'd0);
        chk("ack_irq0", {7'd0, irq0}, 8'd1);
        wr(2'd3, 8'd0); wr(2'd1, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("flag_zero_irq0", {7'd0, irq0}, 8'd0);
        chk("flag_zero_irq1", {7'd0, irq1}, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("flag_zero2_irq1", {7'd0, irq1}, 8'd0);

        // $C001 coincident with event wins; next event loads latch
        wr(2'd2, 8'd0); wr(2'd0, 8'd5); wr(2'd1, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("load5_cnt", cnt0, 8'd5);
        chk("load5_irq0", {7'd0, irq0}, 8'd1);
        wr(2'd0, 8'd9);
        a12_event(1'b1, 2'd1, 8'd0);
        chk("c001_coinc_cnt", cnt0, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("after_c001_cnt", cnt0, 8'd9);

        // $C000 coincident with reload uses the old latch
        wr(2'd1, 8'd0);
        a12_event(1'b1, 2'd0, 8'h20);
        chk("c000_coinc_cnt", cnt0, 8'd9);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("dec_cnt", cnt0, 8'd8);
        wr(2'd1, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("new_latch_cnt", cnt0, 8'h20);

        // enable=0 ignores events
        enable = 1'b0;
        a12_event(1'b0, 2'd0, 8'd0);
        chk("disabled_cnt", cnt0, 8'h20);
        enable = 1'b1;

        // no underflow: 1 -> 0 -> reload 1; irq_enable is 0 so irq stays high
        wr(2'd0, 8'd1); wr(2'd1, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("uf_load_cnt", cnt0, 8'd1);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("uf_zero_cnt", cnt0, 8'd0);
        chk("irq_disabled_irq0", {7'd0, irq0}, 8'd1);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("uf_reload_cnt", cnt0, 8'd1);

        // reach counter=2 with irq low, then reset mid-operation
        wr(2'd3, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("pre_rst_irq1", {7'd0, irq1}, 8'd0);
        wr(2'd0, 8'd3);
        a12_event(1'b0, 2'd0, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("pre_rst_cnt", cnt0, 8'd2);
        chk("pre_rst_irq0", {7'd0, irq0}, 8'd0);
        ppu_a12 = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("async_rst_irq0", {7'd0, irq0}, 8'd1);
        chk("async_rst_irq1", {7'd0, irq1}, 8'd1);
        chk("async_rst_cnt", cnt0, 8'd0);
        tick();
        reset = 1'b0;
        ppu_a12   = 1'b1;
        cpu_write = 1'b1;
        reg_sel   = 2'd0;
        cpu_data  = 8'd7;
        tick();
        cpu_write = 1'b0;
        ppu_a12   = 1'b0;
        repeat (2) tick();
        chk("post_rst_filter_cnt", cnt0, 8'd0);
        a12_event(1'b0, 2'd0, 8'd0);
        chk("post_rst_event_cnt", cnt0, 8'd7);
        chk("post_rst_event_cnt1", cnt1, 8'd7);
        chk("post_rst_irq0", {7'd0, irq0}, 8'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
